// File: rtl/spectral_peak_picker_pkg.sv
// Shared width defaults for the peak picker and the downstream phase vocoder.
// The FSM encodings stay local to the blocks that use them.
package spectral_peak_picker_pkg;

  localparam int DEFAULT_K_WIDTH     = 11;
  localparam int DEFAULT_PHASE_WIDTH = 24;
  localparam int DEFAULT_PHASE_FRAC  = DEFAULT_PHASE_WIDTH - 3;
  localparam int DEFAULT_MAG_WIDTH   = 32;

  // Highest positive-frequency bin for a DFT of length 2**k_width.
  function automatic int default_k_max(input int k_width);
    return (1 << (k_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/spectral_peak_picker_if.sv
// Bin stream in, peak report out; master is the FFT/estimator side, slave is the picker.
interface spectral_peak_picker_if
  import spectral_peak_picker_pkg::*;
#(
  parameter int K_WIDTH     = DEFAULT_K_WIDTH,
  parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
  parameter int MAG_WIDTH   = DEFAULT_MAG_WIDTH
);

  logic [MAG_WIDTH-1:0]   bin_mag;
  logic [PHASE_WIDTH-1:0] bin_phase;
  logic                   bin_valid;
  logic                   bin_last;

  logic [K_WIDTH-1:0]     k_max;
  logic                   k_max_valid;
  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] last_phase;
  logic                   phases_valid;
  logic                   frame_error;

  modport master (
    output bin_mag, bin_phase, bin_valid, bin_last,
    input  k_max, k_max_valid, phase, last_phase, phases_valid, frame_error
  );

  modport slave (
    input  bin_mag, bin_phase, bin_valid, bin_last,
    output k_max, k_max_valid, phase, last_phase, phases_valid, frame_error
  );

endinterface

// File: rtl/phase_bank_ram.sv
// Simple dual-port phase store: one write port, one read port with a registered read.
// Contents are not reset; only addresses written in the current or previous frame are read.
module phase_bank_ram #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/spectral_peak_picker.sv
// Finds the strongest positive-frequency bin of each DFT frame and reports its
// phase in this frame and the previous one, three cycles after the frame's last bin.
module spectral_peak_picker
  import spectral_peak_picker_pkg::*;
#(
  parameter int K_WIDTH     = DEFAULT_K_WIDTH,
  parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
  parameter int MAG_WIDTH   = DEFAULT_MAG_WIDTH,
  parameter int K_MIN       = 1,
  parameter int K_MAX       = default_k_max(K_WIDTH)
) (
  input logic                   clock,
  input logic                   reset,
  spectral_peak_picker_if.slave bus
);

  localparam int DEPTH = K_MAX + 1;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic                   launch;

  logic [K_WIDTH-1:0]     bin_idx_reg, bin_idx_next;
  logic [MAG_WIDTH-1:0]   best_mag_reg, best_mag_next;
  logic [K_WIDTH-1:0]     best_k_reg, best_k_next;
  logic                   bank_sel_reg;

  logic [K_WIDTH-1:0]     k_sel_reg;
  logic                   rd_bank_reg;
  logic                   rd_issue_reg;
  logic                   rd_done_reg;

  logic [K_WIDTH-1:0]     k_max_reg;
  logic [PHASE_WIDTH-1:0] phase_reg;
  logic [PHASE_WIDTH-1:0] last_phase_reg;
  logic                   out_valid_reg;
  logic                   frame_error_reg;

  logic                   at_end, in_store, in_search;
  logic                   frame_end, frame_bad, cand_hit;
  logic [K_WIDTH-1:0]     cand_k;
  logic                   wr_en;
  logic [PHASE_WIDTH-1:0] rd_data [2];

  // Bin N-1 is the all-ones index.
  assign at_end    = (bin_idx_reg == {K_WIDTH{1'b1}});
  assign in_store  = (bin_idx_reg <= K_WIDTH'(K_MAX));
  assign in_search = in_store && (bin_idx_reg >= K_WIDTH'(K_MIN));
  assign frame_end = bus.bin_valid && bus.bin_last && at_end;
  assign frame_bad = bus.bin_valid && (bus.bin_last != at_end);
  assign cand_hit  = bus.bin_valid && in_search && (bus.bin_mag > best_mag_reg);
  assign cand_k    = cand_hit ? bin_idx_reg : best_k_reg;
  assign wr_en     = bus.bin_valid && in_store;

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    case (state_reg)
      PRIME: begin
        if (frame_end) begin
          state_next = RUN;
        end
      end
      RUN: begin
        launch = frame_end;
      end
      default: state_next = PRIME;
    endcase
  end

  // A frame boundary, good or malformed, restarts the counter and the search.
  always_comb begin
    bin_idx_next  = bin_idx_reg;
    best_mag_next = best_mag_reg;
    best_k_next   = best_k_reg;
    if (bus.bin_valid) begin
      if (frame_end || frame_bad) begin
        bin_idx_next  = '0;
        best_mag_next = '0;
        best_k_next   = K_WIDTH'(K_MIN);
      end else begin
        bin_idx_next = bin_idx_reg + K_WIDTH'(1);
        if (cand_hit) begin
          best_mag_next = bus.bin_mag;
          best_k_next   = bin_idx_reg;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      phase_bank_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (PHASE_WIDTH)
      ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en && (bank_sel_reg == (gi != 0))),
        .wr_addr (bin_idx_reg[AW-1:0]),
        .wr_data (bus.bin_phase),
        .rd_en   (rd_issue_reg),
        .rd_addr (k_sel_reg[AW-1:0]),
        .rd_data (rd_data[gi])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= PRIME;
      bin_idx_reg     <= '0;
      best_mag_reg    <= '0;
      best_k_reg      <= '0;
      bank_sel_reg    <= 1'b0;
      k_sel_reg       <= '0;
      rd_bank_reg     <= 1'b0;
      rd_issue_reg    <= 1'b0;
      rd_done_reg     <= 1'b0;
      k_max_reg       <= '0;
      phase_reg       <= '0;
      last_phase_reg  <= '0;
      out_valid_reg   <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bin_idx_reg     <= bin_idx_next;
      best_mag_reg    <= best_mag_next;
      best_k_reg      <= best_k_next;
      frame_error_reg <= frame_bad;
      if (frame_end) begin
        k_sel_reg    <= cand_k;
        rd_bank_reg  <= bank_sel_reg;
        bank_sel_reg <= ~bank_sel_reg;
      end
      rd_issue_reg  <= launch;
      rd_done_reg   <= rd_issue_reg;
      out_valid_reg <= rd_done_reg;
      // rd_bank/k_sel stay stable until the next frame end, which is >3 cycles away.
      if (rd_done_reg) begin
        k_max_reg      <= k_sel_reg;
        phase_reg      <= rd_bank_reg ? rd_data[1] : rd_data[0];
        last_phase_reg <= rd_bank_reg ? rd_data[0] : rd_data[1];
      end
    end
  end

  assign bus.k_max        = k_max_reg;
  assign bus.k_max_valid  = out_valid_reg;
  assign bus.phase        = phase_reg;
  assign bus.last_phase   = last_phase_reg;
  assign bus.phases_valid = out_valid_reg;
  assign bus.frame_error  = frame_error_reg;

endmodule

// File: tb/tb_spectral_peak_picker.sv
// Frame-level bench: each table row is one DFT frame; expected pulses and frame
// errors are queued as frames are driven and matched by a negedge monitor.
module tb_spectral_peak_picker;
  import spectral_peak_picker_pkg::*;

  localparam int N    = 2048;
  localparam int KMAX = 1023;
  localparam int NV   = 13;

  typedef struct {
    int n_bins;
    int last_at;
    int gap;
    int pk_a;
    int mag_a;
    int pk_b;
    int mag_b;
    int ex_a;
    int ex_b;
    int ex_mag;
    int pk_phase;
    bit zero_all;
    int exp_k;
  } vec_t;

  typedef struct {
    int          due;
    logic [10:0] k;
    logic [23:0] ph;
    logic [23:0] lph;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spectral_peak_picker_if bus ();

  spectral_peak_picker dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  int          err_q[$];
  logic [23:0] prev_ph [KMAX+1];
  logic [23:0] cur_ph  [KMAX+1];
  logic [31:0] mags    [N];
  bit          primed = 1'b0;
  int          seed = 0;
  vec_t        vecs [NV];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_zero();
    check("rst_k_max", 64'(bus.k_max), 64'd0);
    check("rst_phase", 64'(bus.phase), 64'd0);
    check("rst_last_phase", 64'(bus.last_phase), 64'd0);
    check("rst_k_max_valid", 64'(bus.k_max_valid), 64'd0);
    check("rst_phases_valid", 64'(bus.phases_valid), 64'd0);
    check("rst_frame_error", 64'(bus.frame_error), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      bus.bin_valid = 1'b0;
      bus.bin_last  = 1'b0;
    end
  endtask

  task automatic send_frame(input vec_t v);
    logic [23:0] ph;
    logic        lst;
    exp_t        e;
    idle(v.gap);
    seed++;
    for (int k = 0; k < N; k++) mags[k] = v.zero_all ? 32'd0 : 32'($urandom_range(1, 1000));
    if (!v.zero_all) begin
      mags[v.pk_a] = 32'(v.mag_a);
      if (v.pk_b >= 0) mags[v.pk_b] = 32'(v.mag_b);
      if (v.ex_a >= 0) mags[v.ex_a] = 32'(v.ex_mag);
      if (v.ex_b >= 0) mags[v.ex_b] = 32'(v.ex_mag);
    end
    for (int i = 0; i < v.n_bins; i++) begin
      ph = {seed[7:0], i[10:0], 5'd0};
      if (i == v.pk_a && v.pk_phase >= 0) ph = v.pk_phase[23:0];
      if (i <= KMAX) cur_ph[i] = ph;
      lst = (i == v.last_at);
      @(posedge clock); #1;
      bus.bin_valid = 1'b1;
      bus.bin_mag   = mags[i];
      bus.bin_phase = ph;
      bus.bin_last  = lst;
      if (lst && i != N - 1) begin
        err_q.push_back(cyc + 1);
      end else if (!lst && i == N - 1) begin
        err_q.push_back(cyc + 1);
      end else if (lst) begin
        if (primed) begin
          e.due = cyc + 3;
          e.k   = v.exp_k[10:0];
          e.ph  = cur_ph[v.exp_k];
          e.lph = prev_ph[v.exp_k];
          exp_q.push_back(e);
        end
        prev_ph = cur_ph;
        primed  = 1'b1;
      end
    end
  endtask

  // Output monitor: one line per pulse or frame error.
  always @(negedge clock) begin
    exp_t e;
    int   d;
    if (!reset) begin
      if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL pulse_missing cycle=%0d required_cycle=%0d k=%0d", cyc, e.due, e.k);
      end
      if (err_q.size() != 0 && err_q[0] < cyc) begin
        d = err_q.pop_front();
        checks++; errors++;
        $display("FAIL frame_error_missing cycle=%0d required_cycle=%0d", cyc, d);
      end
      if (bus.k_max_valid || bus.phases_valid) begin
        check("valid_pair", 64'(bus.phases_valid), 64'(bus.k_max_valid));
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse k_max=%0d required no pulse", bus.k_max);
        end else begin
          e = exp_q.pop_front();
          $display("pulse cyc=%0d k_max=%0d phase=%06h last_phase=%06h", cyc, bus.k_max,
                   bus.phase, bus.last_phase);
          check("pulse_cycle", 64'(cyc), 64'(e.due));
          check("k_max", 64'(bus.k_max), 64'(e.k));
          check("phase", 64'(bus.phase), 64'(e.ph));
          check("last_phase", 64'(bus.last_phase), 64'(e.lph));
        end
      end
      if (bus.frame_error) begin
        $display("frame_error cyc=%0d", cyc);
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_error cycle=%0d required none", cyc);
        end else begin
          d = err_q.pop_front();
          check("frame_error_cycle", 64'(cyc), 64'(d));
        end
      end
    end
  end

  initial begin
    vec_t v;
    exp_t dropped;
    bus.bin_valid = 1'b0;
    bus.bin_last  = 1'b0;
    bus.bin_mag   = '0;
    bus.bin_phase = '0;

    //              n_bins last_at gap pk_a mag_a pk_b mag_b ex_a ex_b ex_mag pk_phase zero exp_k
    vecs[0]  = '{N,    N-1,  2, 100,  5000,  -1,    0,  -1,   -1,     0, 'h100000, 0, 100};
    vecs[1]  = '{N,    N-1,  2, 100,  5000,  -1,    0,  -1,   -1,     0, 'h180000, 0, 100};
    vecs[2]  = '{N,    N-1,  2,  40,  9000,  70, 9000,   0, 1500, 20000,       -1, 0,  40};
    vecs[3]  = '{N,    N-1,  2,   0,     0,  -1,    0,  -1,   -1,     0,       -1, 1,   1};
    vecs[4]  = '{1001, 1000, 2, 200,  6000,  -1,    0,  -1,   -1,     0,       -1, 0, 200};
    vecs[5]  = '{N,    N-1,  2, 500,  7000,  -1,    0,  -1,   -1,     0,       -1, 0, 500};
    vecs[6]  = '{N,    -1,   2, 600,  7000,  -1,    0,  -1,   -1,     0,       -1, 0, 600};
    vecs[7]  = '{N,    N-1,  2,   7,  7000,  -1,    0,  -1,   -1,     0,       -1, 0,   7};
    vecs[8]  = '{N,    N-1,  0,  10,  8000,  -1,    0,  -1,   -1,     0,       -1, 0,  10};
    vecs[9]  = '{N,    N-1,  0,  20,  8000,  -1,    0,  -1,   -1,     0,       -1, 0,  20};
    vecs[10] = '{N,    N-1,  0,  30,  8000,  -1,    0,  -1,   -1,     0,       -1, 0,  30};
    vecs[11] = '{N,    N-1,  0, 1023, 9000,  -1,    0,   0, 1024, 50000,       -1, 0, 1023};
    vecs[12] = '{N,    N-1,  0,   1,  9000,  -1,    0,  -1, 2047, 60000,       -1, 0,   1};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_zero();

    for (int i = 0; i < NV; i++) send_frame(vecs[i]);
    idle(8);
    @(negedge clock);
    check("hold_k_max", 64'(bus.k_max), 64'(vecs[NV-1].exp_k));
    check("hold_valid_low", 64'(bus.k_max_valid), 64'd0);

    // Reset in the middle of a frame, then restart from PRIME with back-to-back frames.
    v = vecs[7];
    v.n_bins = 600;
    v.last_at = -1;
    send_frame(v);
    @(posedge clock); #1;
    reset = 1'b1;
    bus.bin_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    primed = 1'b0;
    @(negedge clock);
    check_zero();
    for (int i = 8; i <= 10; i++) begin
      v = vecs[i];
      if (i == 8) v.gap = 1;
      send_frame(v);
    end
    idle(8);

    // Reset after a frame end but before its readout pulse: the pulse must be dropped.
    v = vecs[5];
    send_frame(v);
    dropped = exp_q.pop_back();
    @(posedge clock); #1;
    bus.bin_valid = 1'b0;
    bus.bin_last  = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    primed = 1'b0;
    @(negedge clock);
    check_zero();
    idle(8);
    @(negedge clock);
    check("dropped_pulse_k_max", 64'(bus.k_max), 64'd0);

    check("pending_pulses", 64'(exp_q.size()), 64'd0);
    check("pending_frame_errors", 64'(err_q.size()), 64'd0);
    if (dropped.k != 11'd500) $display("note: dropped readout was for k=%0d", dropped.k);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
